atomic_alu_sequencer: RTL and testbench
=======================================

# atomic_alu_sequencer

- Parametrised command sequencer and register file for the atomic ALU.
- Accepts encoded commands over a valid/ready handshake and reads two operands from an NREGS x DATA_W register file.
- Drives the external combinational ALU, then writes the result back and reports completion.
- Adds a single-command atomic compare-and-swap (CAS) whose success flag is written to the top register.

## Interface
Parameters:
- DATA_W, 32, register and ALU operand width (≥ 8)
- NREGS, 8, register count; power of two, ≥ 4; ADDR_W = $clog2(NREGS) is derived, CMD_W = 3 + 3*ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd  in  CMD_W  {op[2:0], a1, a2, a3}, op in MSBs, a3 in LSBs
- alu_op  out  3  opcode to ALU
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_y  in  DATA_W  ALU result (combinational from alu_op/a/b)
- alu_o, alu_c, alu_z, alu_n  in  1  ALU flags
- done  out  1  one-cycle pulse, command retired
- flags  out  4  {O,C,Z,N} captured at last retirement
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr]

## Operation
- FSM states: IDLE, EXEC.
  - IDLE: cmd_ready=1; on cmd_valid && cmd_ready → EXEC.
  - EXEC: cmd_ready=0; unconditionally → IDLE.
- At the accept edge the following are registered:
  - op < 7: alu_op=op, alu_a=reg[a1], alu_b=reg[a2], with a3 latched as destination.
  - op = 7 (CAS): alu_op=3'b001 (subtract), alu_a=reg[a1] (target), alu_b=reg[a3] (expected), with a2 latched as the new-value source.
- At the EXEC edge:
  - flags ← {alu_o,alu_c,alu_z,alu_n}; done ← 1.
  - op < 7: reg[a3] ← alu_y.
  - CAS, alu_z=1: reg[a1] ← reg[a2], then reg[NREGS-1] ← 1.
  - CAS, alu_z=0: reg[NREGS-1] ← 0; no other write.
- Write collisions: on CAS with a1 = NREGS-1, the status write wins. Only one write per register per cycle.
- a2 is read at the EXEC edge, not at accept. No other writer exists, so the value is the same.
- alu_op/alu_a/alu_b hold their values outside EXEC.

## Timing
- Reset (async assert, sync deassert by system) sets:
  - all registers 0, flags 0, done 0, alu_op 0, alu_a/alu_b 0, state IDLE (so cmd_ready=1 once rst_n=1).
- Latency: accept at edge E0 → writeback and done=1 at E1 → done visible in the cycle after E1.
- Throughput: one command per 2 cycles. A command accepted at E2 sees E1's writeback, so there are no hazards.
- cmd_ready is low throughout EXEC. cmd/cmd_valid are ignored in EXEC and need not be held.
- done is high for exactly one cycle. In that same cycle cmd_ready=1, so back-to-back accept is allowed.
- Reset asserted during EXEC: the command is aborted, no register write, done stays 0.
- dbg_data is purely combinational. A same-cycle write appears after the edge.

## Configuration
- ATOMIC_ALU_R0_ZERO_EN defined:
  - reg[0] is hardwired to 0, so reads of address 0 (operands, CAS sources, dbg) return 0.
  - Writes to address 0 are discarded. flags and done still update.
- Undefined: reg[0] is an ordinary writable register.

## Test plan
- Reset, NREGS=8, DATA_W=32: every dbg_addr reads 0, cmd_ready=1, done=0, flags=0.
- Add with reg1=5, reg2=7 (op=0, a1=1, a2=2, a3=3):
  - alu_op=0, alu_a=5, alu_b=7 after accept.
  - done one cycle later; reg3 = ALU result 12.
- CAS success with reg1=9, reg3=9, reg2=0xAA (op=7, a1=1, a2=2, a3=3):
  - alu_op=1.
  - reg1=0xAA, reg7=1, flags.Z=1.
- CAS failure with reg1=9, reg3=4: reg1 stays 9, reg7=0, flags.Z=0.
- Back-to-back: cmd_valid held high for two dependent adds.
  - Second accepted the cycle done pulses, 2 cycles after the first.
  - Second sees the first's result.
- rst_n pulled low during EXEC of a write to reg5=0x33: reg5=0 after reset, no done pulse. With ATOMIC_ALU_R0_ZERO_EN, a write to reg0 leaves dbg reg0=0.

Source files
------------

// File: rtl/atomic_alu_sequencer.sv
// ---------------------------------------------------------------------------
// atomic_alu_sequencer
//
// Command sequencer and NREGS x DATA_W register file for an external,
// purely combinational ALU. A command is accepted in IDLE, its operands are
// registered onto the ALU inputs, and one cycle later (EXEC) the ALU result
// and flags are written back and `done` pulses. Opcode 7 is an atomic
// compare-and-swap: reg[a1] is compared with reg[a3] through an ALU
// subtract; on equality reg[a1] takes reg[a2]. The success bit always lands
// in the top register, reg[NREGS-1].
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high exactly when the FSM is in IDLE. cmd/cmd_valid are not
// looked at in EXEC and need not be held.
//
// Optional feature (macro ATOMIC_ALU_R0_ZERO_EN): reg[0] reads as zero
// everywhere and writes to it are dropped.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready/cmd    command handshake, cmd = {op, a1, a2, a3}
//   alu_op/alu_a/alu_b         registered ALU inputs, held outside EXEC
//   alu_y, alu_o/c/z/n         ALU result and flags
//   done                       one-cycle retirement pulse
//   flags                      {O,C,Z,N} captured at last retirement
//   dbg_addr/dbg_data          combinational register file peek
// ---------------------------------------------------------------------------
module atomic_alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS),
    localparam int CMD_W  = 3 + 3 * ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_o,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              done,
    output logic [3:0]        flags,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NREGS - 1);
    localparam logic [2:0]        OP_CAS   = 3'd7;
    localparam logic [2:0]        OP_SUB   = 3'd1;

    state_t              r_state;
    logic [DATA_W-1:0]   r_regs [NREGS];
    logic                r_is_cas;
    logic [ADDR_W-1:0]   r_wr_addr;   // a3 for ALU ops, a1 (target) for CAS
    logic [ADDR_W-1:0]   r_src_addr;  // a2: CAS new-value source
    logic [2:0]          r_alu_op;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic                r_done;
    logic [3:0]          r_flags;

    logic [2:0]          w_op;
    logic [ADDR_W-1:0]   w_a1;
    logic [ADDR_W-1:0]   w_a2;
    logic [ADDR_W-1:0]   w_a3;
    logic                w_wr_ok;

    assign w_op = cmd[CMD_W-1 -: 3];
    assign w_a1 = cmd[3*ADDR_W-1 -: ADDR_W];
    assign w_a2 = cmd[2*ADDR_W-1 -: ADDR_W];
    assign w_a3 = cmd[ADDR_W-1:0];

    // Register file read port; address 0 may be hardwired to zero.
    function automatic logic [DATA_W-1:0] rf_rd(input logic [ADDR_W-1:0] addr);
`ifdef ATOMIC_ALU_R0_ZERO_EN
        if (addr == '0) begin
            return '0;
        end
`endif
        return r_regs[addr];
    endfunction

    // Data write-enable for the retiring command's destination.
`ifdef ATOMIC_ALU_R0_ZERO_EN
    assign w_wr_ok = (r_wr_addr != '0);
`else
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_cas   <= 1'b0;
            r_wr_addr  <= '0;
            r_src_addr <= '0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_done     <= 1'b0;
            r_flags    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state    <= S_EXEC;
                        r_is_cas   <= (w_op == OP_CAS);
                        r_src_addr <= w_a2;
                        r_alu_a    <= rf_rd(w_a1);
                        if (w_op == OP_CAS) begin
                            // Compare target against expected via subtract; Z means equal.
                            r_alu_op  <= OP_SUB;
                            r_alu_b   <= rf_rd(w_a3);
                            r_wr_addr <= w_a1;
                        end else begin
                            r_alu_op  <= w_op;
                            r_alu_b   <= rf_rd(w_a2);
                            r_wr_addr <= w_a3;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_flags <= {alu_o, alu_c, alu_z, alu_n};
                    if (!r_is_cas) begin
                        if (w_wr_ok) begin
                            r_regs[r_wr_addr] <= alu_y;
                        end
                    end else begin
                        if (alu_z && w_wr_ok) begin
                            r_regs[r_wr_addr] <= rf_rd(r_src_addr);
                        end
                        // Placed after the swap write so that the status bit
                        // wins when the CAS target is the top register.
                        r_regs[TOP_ADDR] <= DATA_W'(alu_z);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign done      = r_done;
    assign flags     = r_flags;
    assign dbg_data  = rf_rd(dbg_addr);

endmodule

// File: tb/tb_atomic_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_atomic_alu_sequencer
//
// Bench for atomic_alu_sequencer (DATA_W=32, NREGS=8). Supplies a
// combinational ALU model, keeps a register-file reference model computed
// from the command rules, and runs a directed vector table, hand-written
// multi-cycle sequences (back-to-back, reset in EXEC, reg0 write) and a
// randomized command stream.
//
// ALU op map used by this bench: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a,
// 6 load (y = tb_imm, lets the bench seed registers), 7 add.
// ---------------------------------------------------------------------------
module tb_atomic_alu_sequencer;

    localparam int DATA_W = 32;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int CMD_W  = 3 + 3 * ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_o, alu_c, alu_z, alu_n;
    logic              done;
    logic [3:0]        flags;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] tb_imm;

    atomic_alu_sequencer #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
        .done(done), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ---------------- external ALU ----------------
    // Returns {O, C, Z, N, y}.
    function automatic logic [DATA_W+3:0] alu_f(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] imm);
        logic [DATA_W:0]   s;
        logic [DATA_W-1:0] y;
        logic              o, c;
        o = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[DATA_W-1:0];
                c = s[DATA_W];
                o = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            3'd1: begin
                y = a - b;
                c = (a < b);
                o = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            3'd2:    y = a & b;
            3'd3:    y = a | b;
            3'd4:    y = a ^ b;
            3'd5:    y = ~a;
            3'd6:    y = imm;
            default: y = a + b;
        endcase
        return {o, c, (y == '0), y[DATA_W-1], y};
    endfunction

    assign {alu_o, alu_c, alu_z, alu_n, alu_y} = alu_f(alu_op, alu_a, alu_b, tb_imm);

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_regs [NREGS];
    logic [3:0]        m_flags;

    function automatic logic [DATA_W-1:0] m_rd(input logic [ADDR_W-1:0] addr);
`ifdef ATOMIC_ALU_R0_ZERO_EN
        if (addr == 0) return '0;
`endif
        return m_regs[addr];
    endfunction

    task automatic m_wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
`ifdef ATOMIC_ALU_R0_ZERO_EN
        if (addr == 0) return;
`endif
        m_regs[addr] = val;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_flags = '0;
    endtask

    // Applies one command to the model; reports the expected ALU inputs.
    task automatic model_exec(input logic [2:0] op, input logic [ADDR_W-1:0] a1,
                              input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3,
                              input logic [DATA_W-1:0] imm,
                              output logic [2:0] e_op, output logic [DATA_W-1:0] e_a,
                              output logic [DATA_W-1:0] e_b);
        logic [DATA_W+3:0] r;
        logic [DATA_W-1:0] newv;
        logic              eq;
        if (op != 3'd7) begin
            e_op = op;
            e_a  = m_rd(a1);
            e_b  = m_rd(a2);
            r    = alu_f(op, e_a, e_b, imm);
            m_flags = r[DATA_W+3:DATA_W];
            m_wr(a3, r[DATA_W-1:0]);
        end else begin
            e_op = 3'd1;
            e_a  = m_rd(a1);
            e_b  = m_rd(a3);
            newv = m_rd(a2);
            eq   = (e_a == e_b);
            r    = alu_f(3'd1, e_a, e_b, imm);
            m_flags = r[DATA_W+3:DATA_W];
            if (eq) m_wr(a1, newv);
            m_regs[NREGS-1] = DATA_W'(eq);
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_reg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        dbg_addr = addr;
        #1;
        chk($sformatf("reg%0d", addr), dbg_data, exp);
    endtask

    // ---------------- driver ----------------
    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("ready_timeout", DATA_W'(cmd_ready), 1);
    endtask

    // Issues one command and checks accept/EXEC/retire behaviour against the model.
    task automatic apply_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] a1,
                             input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3,
                             input logic [DATA_W-1:0] imm,
                             output logic [DATA_W-1:0] got_a, output logic [DATA_W-1:0] got_b);
        logic [2:0]        e_op;
        logic [DATA_W-1:0] e_a, e_b;
        @(negedge clk);
        wait_ready();
        tb_imm    = imm;
        cmd       = {op, a1, a2, a3};
        cmd_valid = 1'b1;
        model_exec(op, a1, a2, a3, imm, e_op, e_a, e_b);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        got_a = alu_a;
        got_b = alu_b;
        chk("alu_op", DATA_W'(alu_op), DATA_W'(e_op));
        chk("alu_a", alu_a, e_a);
        chk("alu_b", alu_b, e_b);
        chk("ready_in_exec", DATA_W'(cmd_ready), 0);
        chk("done_in_exec", DATA_W'(done), 0);
        @(posedge clk);
        #1;
        chk("done_pulse", DATA_W'(done), 1);
        chk("flags", DATA_W'(flags), DATA_W'(m_flags));
        chk("ready_after", DATA_W'(cmd_ready), 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]        op;
        logic [ADDR_W-1:0] a1, a2, a3;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] ea, eb;
        logic [ADDR_W-1:0] c1a;
        logic [DATA_W-1:0] c1v;
        logic [ADDR_W-1:0] c2a;
        logic [DATA_W-1:0] c2v;
        logic              ez;
    } vec_t;

    function automatic vec_t mk(input int op, input int a1, input int a2, input int a3,
                                input int imm, input int ea, input int eb,
                                input int c1a, input int c1v, input int c2a, input int c2v,
                                input int ez);
        vec_t v;
        v.op = 3'(op); v.a1 = ADDR_W'(a1); v.a2 = ADDR_W'(a2); v.a3 = ADDR_W'(a3);
        v.imm = DATA_W'(imm); v.ea = DATA_W'(ea); v.eb = DATA_W'(eb);
        v.c1a = ADDR_W'(c1a); v.c1v = DATA_W'(c1v);
        v.c2a = ADDR_W'(c2a); v.c2v = DATA_W'(c2v);
        v.ez = ez[0];
        return v;
    endfunction

    vec_t vt [12];

    initial begin
        logic [DATA_W-1:0] ga, gb;
        logic [2:0]        e_op;
        logic [DATA_W-1:0] e_a, e_b;
        logic [2:0]        rop;

        cmd_valid = 1'b0;
        cmd       = '0;
        dbg_addr  = '0;
        tb_imm    = '0;
        m_reset();

        //          op a1 a2 a3 imm    ea     eb     c1a c1v    c2a c2v   ez
        vt[0]  = mk(6, 0, 0, 1, 5,     0,     0,     1,  5,     3,  0,    0);
        vt[1]  = mk(6, 0, 0, 2, 7,     0,     0,     2,  7,     1,  5,    0);
        vt[2]  = mk(0, 1, 2, 3, 0,     5,     7,     3,  12,    1,  5,    0);
        vt[3]  = mk(6, 0, 0, 1, 9,     0,     0,     1,  9,     3,  12,   0);
        vt[4]  = mk(6, 0, 0, 3, 9,     0,     0,     3,  9,     1,  9,    0);
        vt[5]  = mk(6, 0, 0, 2, 'hAA,  0,     0,     2,  'hAA,  3,  9,    0);
        vt[6]  = mk(7, 1, 2, 3, 0,     9,     9,     1,  'hAA,  7,  1,    1);
        vt[7]  = mk(6, 0, 0, 1, 9,     0,     0,     1,  9,     7,  1,    0);
        vt[8]  = mk(6, 0, 0, 3, 4,     0,     0,     3,  4,     1,  9,    0);
        vt[9]  = mk(7, 1, 2, 3, 0,     9,     4,     1,  9,     7,  0,    0);
        vt[10] = mk(1, 2, 3, 4, 0,     'hAA,  4,     4,  'hA6,  2,  'hAA, 0);
        vt[11] = mk(1, 4, 4, 5, 0,     'hA6,  'hA6,  5,  0,     4,  'hA6, 1);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", DATA_W'(cmd_ready), 1);
        chk("reset_done", DATA_W'(done), 0);
        chk("reset_flags", DATA_W'(flags), 0);
        chk("reset_alu_a", alu_a, 0);
        for (int i = 0; i < NREGS; i++) chk_reg(ADDR_W'(i), 0);

        // ---- directed table ----
        for (int i = 0; i < 12; i++) begin
            apply_cmd(vt[i].op, vt[i].a1, vt[i].a2, vt[i].a3, vt[i].imm, ga, gb);
            chk($sformatf("vec%0d_a", i), ga, vt[i].ea);
            chk($sformatf("vec%0d_b", i), gb, vt[i].eb);
            chk($sformatf("vec%0d_z", i), DATA_W'(flags[1]), DATA_W'(vt[i].ez));
            chk_reg(vt[i].c1a, vt[i].c1v);
            chk_reg(vt[i].c2a, vt[i].c2v);
        end

        // ---- back-to-back dependent adds, cmd_valid held high ----
        // reg6 = reg1 + reg2 = 9 + 0xAA = 0xB3; reg5 = reg6 + reg6 = 0x166.
        @(negedge clk);
        wait_ready();
        cmd       = {3'd0, 3'd1, 3'd2, 3'd6};
        cmd_valid = 1'b1;
        model_exec(3'd0, 3'd1, 3'd2, 3'd6, tb_imm, e_op, e_a, e_b);
        @(posedge clk);
        #1;
        cmd = {3'd0, 3'd6, 3'd6, 3'd5};
        chk("b2b_exec1_ready", DATA_W'(cmd_ready), 0);
        @(posedge clk);
        #1;
        chk("b2b_done1", DATA_W'(done), 1);
        chk("b2b_ready_with_done", DATA_W'(cmd_ready), 1);
        model_exec(3'd0, 3'd6, 3'd6, 3'd5, tb_imm, e_op, e_a, e_b);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("b2b_second_accepted", DATA_W'(cmd_ready), 0);
        chk("b2b_alu_a", alu_a, 'hB3);
        chk("b2b_alu_b", alu_b, e_b);
        chk("b2b_done_low", DATA_W'(done), 0);
        @(posedge clk);
        #1;
        chk("b2b_done2", DATA_W'(done), 1);
        chk_reg(3'd6, 'hB3);
        chk_reg(3'd5, 'h166);
        @(posedge clk);
        #1;
        chk("done_one_cycle", DATA_W'(done), 0);
        chk_reg(3'd5, m_rd(3'd5));

        // ---- reset asserted during EXEC of a write of 0x33 to reg5 ----
        @(negedge clk);
        wait_ready();
        tb_imm    = 'h33;
        cmd       = {3'd6, 3'd0, 3'd0, 3'd5};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_exec_no_done", DATA_W'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_exec_ready", DATA_W'(cmd_ready), 1);
        chk("rst_exec_flags", DATA_W'(flags), 0);
        chk("rst_exec_alu_op", DATA_W'(alu_op), 0);
        chk_reg(3'd5, 0);
        chk_reg(3'd6, 0);

        // ---- write to reg0 ----
        apply_cmd(3'd6, 3'd0, 3'd0, 3'd0, 'h55, ga, gb);
`ifdef ATOMIC_ALU_R0_ZERO_EN
        chk_reg(3'd0, 0);
`else
        chk_reg(3'd0, 'h55);
`endif

        // ---- randomized stream against the model ----
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            apply_cmd(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) == 1) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom),
                      ga, gb);
            for (int i = 0; i < NREGS; i++) chk_reg(ADDR_W'(i), m_rd(ADDR_W'(i)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
